dw_mem_sequencer: RTL and testbench
===================================

Name: dw_mem_sequencer

Overview:
- Controls the single 32-bit data-memory port for the MEM stage. Inputs come from the EX/MEM pipeline register outputs.
- Splits double-word (float DW) loads and stores into two word beats, addr and addr+4, and handles variable-latency memory through a req/ready handshake.
- Asserts stall to hold PC, IF/ID, ID/EX and EX/MEM while an access is in progress.
- Reports misaligned accesses and memory timeouts.

Parameters:
- LOAD_WBSRC, 2'b01: WBsrc encoding that selects memory data, i.e. identifies a load.
- TIMEOUT, 255: maximum cycles a single beat may wait for mem_ready; range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ex_flush  in  1  EX/MEM oFlush; 1 = bubble, no access.
- ex_byte  in  1  EX/MEM oByte; byte access. Ignored when ex_dw=1.
- ex_mwrite  in  1  EX/MEM oMWrite; store.
- ex_dw  in  1  EX/MEM oDW; double-word access.
- ex_wbsrc  in  2  EX/MEM oWBsrc.
- ex_addr  in  32  EX/MEM oALUout1; effective address.
- ex_wdata_lo  in  32  store data, beat 0.
- ex_wdata_hi  in  32  store data, beat 1.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, equal to ex_mwrite.
- mem_byte  out  1  byte access, equal to ex_byte & ~ex_dw.
- mem_addr  out  32  beat address.
- mem_wdata  out  32  beat write data.
- mem_ready  in  1  beat complete; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read data.
- rd_lo  out  32  load result, low word, to MEM/WB.
- rd_hi  out  32  load result, high word (DW only), to MEM/WB.
- stall  out  1  hold upstream pipeline, including EX/MEM.
- misalign_err  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse.

Behaviour:
- Definitions:
  - acc = ~ex_flush & (ex_mwrite | ex_wbsrc==LOAD_WBSRC).
  - mis = ex_dw ? ex_addr[2:0]!=0 : (~ex_byte & ex_addr[1:0]!=0).
  - beat_done = mem_req & mem_ready.
- States are IDLE, B0_WAIT and B1. Register lo_q holds beat 0 read data (32 bits). Register wait_cnt holds beat wait cycles (8 bits).
- Reset (rst=1 at posedge): state to IDLE, lo_q to 0, wait_cnt to 0. While rst=1, force mem_req, stall, misalign_err and bus_err to 0.
- mem_req = (IDLE & acc & ~mis) | B0_WAIT | B1.
- mem_addr = B1 ? {ex_addr[31:3],3'b100} : ex_addr.
- mem_wdata = B1 ? ex_wdata_hi : ex_wdata_lo.
- All outputs are combinational from state and inputs.
- stall = mem_req & ~(beat_done & last) & ~timeout, where:
  - last = (B1) | (~ex_dw & state!=B1).
  - timeout = (wait_cnt==TIMEOUT) & ~mem_ready.
- rd_lo = ex_dw ? lo_q : mem_rdata.
- rd_hi = mem_rdata. Downstream samples both on the unstalled cycle.
- IDLE transitions:
  - acc & mis: pulse misalign_err, no request, stall=0, stay IDLE.
  - acc & ~mis, beat_done & ~ex_dw: done in zero extra cycles; stay IDLE.
  - acc & ~mis, beat_done & ex_dw: lo_q <= mem_rdata, go to B1.
  - acc & ~mis, ~mem_ready: go to B0_WAIT.
- B0_WAIT: same completion rules as IDLE. If ex_flush=1 at beat 0 completion, go to IDLE without issuing beat 1, and stall drops that cycle.
- B1: on beat_done, go to IDLE and release stall.
- wait_cnt:
  - Increments each cycle mem_req=1 & ~mem_ready.
  - Clears on beat_done, on timeout, and on entering B1.
  - On timeout: pulse bus_err, drop mem_req the next cycle (go IDLE), stall=0 in the timeout cycle.
  - A completed beat 0 store is not rolled back.
- Upstream holds EX/MEM inputs stable while stall=1. The block does not re-sample ex_* mid-access except ex_flush at beat 0 completion.
- DW latency is a minimum of 2 cycles (one per beat). A single word with mem_ready=1 completes in 1 cycle with no stall.
- Back-to-back accesses: the next instruction is evaluated in IDLE in the cycle after the previous access completes.

Test Plan:
- Word load, addr 0x100, mem_ready=1, rdata 0xDEADBEEF -> mem_req=1 one cycle, stall=0, rd_lo=0xDEADBEEF.
- DW load, addr 0x208, ready=1 each cycle, rdata 0x11111111 then 0x22222222 -> addrs 0x208, 0x20C; stall=1 cycle 1, 0 cycle 2; rd_lo=0x11111111, rd_hi=0x22222222.
- DW store, addr 0x10, beat 0 ready delayed 3 cycles -> wdata_lo at 0x10 held 4 cycles with stall=1, then wdata_hi at 0x14; mem_we=1 throughout.
- Misaligned word at 0x102 and DW at 0x204 -> misalign_err pulses, mem_req=0, stall=0; byte access at 0x103 -> normal request.
- TIMEOUT=4, mem_ready never asserted -> bus_err pulses on the 5th waiting cycle, stall drops, next cycle mem_req=0 and state is IDLE.
- rst asserted while in B1 -> next cycle IDLE, mem_req=0, stall=0, lo_q=0; ex_flush=1 with a load -> no request.

Source files
------------

// File: rtl/dw_mem_sequencer_if.sv
// Data-memory port bundle between the MEM-stage sequencer and the memory.
interface dw_mem_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dw_mem_sequencer.sv
// MEM-stage sequencer for the single 32-bit data-memory port. Splits
// double-word accesses into two word beats, waits on variable-latency
// memory, stalls the upstream pipeline, and flags misalign/timeout errors.
module dw_mem_sequencer #(
    parameter logic [1:0]  LOAD_WBSRC = 2'b01,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_flush,
    input  logic        ex_byte,
    input  logic        ex_mwrite,
    input  logic        ex_dw,
    input  logic [1:0]  ex_wbsrc,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata_lo,
    input  logic [31:0] ex_wdata_hi,
    dw_mem_sequencer_if.master mem,
    output logic [31:0] rd_lo,
    output logic [31:0] rd_hi,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        B0_WAIT,
        B1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lo_q, lo_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic acc;
    logic mis;
    logic req_raw;
    logic beat_done;
    logic last;
    logic timeout;
    logic flush_done;

    // Decode the pending access and the per-cycle handshake conditions.
    always_comb begin
        acc        = ~ex_flush & (ex_mwrite | (ex_wbsrc == LOAD_WBSRC));
        mis        = ex_dw ? (ex_addr[2:0] != 3'b000)
                           : (~ex_byte & (ex_addr[1:0] != 2'b00));
        // Any non-IDLE state has a beat outstanding.
        req_raw    = (state_q == IDLE) ? (acc & ~mis) : 1'b1;
        beat_done  = req_raw & mem.mem_ready;
        last       = (state_q == B1) | (~ex_dw & (state_q != B1));
        timeout    = (wait_cnt_q == TIMEOUT_C) & ~mem.mem_ready;
        // A flush arriving as beat 0 completes abandons beat 1.
        flush_done = (state_q == B0_WAIT) & beat_done & ex_flush;
    end

    assign mem.mem_req   = ~rst & req_raw;
    assign mem.mem_we    = ex_mwrite;
    assign mem.mem_byte  = ex_byte & ~ex_dw;
    assign mem.mem_addr  = (state_q == B1) ? {ex_addr[31:3], 3'b100} : ex_addr;
    assign mem.mem_wdata = (state_q == B1) ? ex_wdata_hi : ex_wdata_lo;

    assign stall        = ~rst & req_raw & ~(beat_done & (last | flush_done)) & ~timeout;
    assign misalign_err = ~rst & (state_q == IDLE) & acc & mis;
    assign bus_err      = ~rst & req_raw & timeout;

    assign rd_lo = ex_dw ? lo_q : mem.mem_rdata;
    assign rd_hi = mem.mem_rdata;

    // Next-state, beat-0 capture and wait-counter update.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        wait_cnt_d = wait_cnt_q;
        if (req_raw) begin
            if (timeout) begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end else if (mem.mem_ready) begin
                wait_cnt_d = '0;
                if ((state_q == B1) || flush_done || ~ex_dw) begin
                    state_d = IDLE;
                end else begin
                    state_d = B1;
                    lo_d    = mem.mem_rdata;
                end
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (state_q == IDLE) begin
                    state_d = B0_WAIT;
                end
            end
        end
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lo_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_dw_mem_sequencer.sv
// Self-checking bench for dw_mem_sequencer: table of single-cycle IDLE
// vectors plus hand-written multi-cycle sequences.
module tb_dw_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_flush, ex_byte, ex_mwrite, ex_dw;
    logic [1:0]  ex_wbsrc;
    logic [31:0] ex_addr, ex_wdata_lo, ex_wdata_hi;
    logic [31:0] rd_lo, rd_hi;
    logic        stall, misalign_err, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dw_mem_sequencer_if mif();

    dw_mem_sequencer #(
        .LOAD_WBSRC (2'b01),
        .TIMEOUT    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_flush     (ex_flush),
        .ex_byte      (ex_byte),
        .ex_mwrite    (ex_mwrite),
        .ex_dw        (ex_dw),
        .ex_wbsrc     (ex_wbsrc),
        .ex_addr      (ex_addr),
        .ex_wdata_lo  (ex_wdata_lo),
        .ex_wdata_hi  (ex_wdata_hi),
        .mem          (mif),
        .rd_lo        (rd_lo),
        .rd_hi        (rd_hi),
        .stall        (stall),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    typedef struct {
        logic        fl, by, wr, dw;
        logic [1:0]  wb;
        logic [31:0] addr, wlo;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req, e_we, e_byte;
        logic [31:0] e_addr, e_wdata;
        logic        e_stall, e_mis;
        logic [31:0] e_rdlo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic by, input logic wr, input logic dw,
                         input logic [1:0] wb, input logic [31:0] addr,
                         input logic [31:0] wlo, input logic [31:0] whi,
                         input logic rdy, input logic [31:0] rdata);
        ex_flush      = fl;
        ex_byte       = by;
        ex_mwrite     = wr;
        ex_dw         = dw;
        ex_wbsrc      = wb;
        ex_addr       = addr;
        ex_wdata_lo   = wlo;
        ex_wdata_hi   = whi;
        mif.mem_ready = rdy;
        mif.mem_rdata = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // word load, store, misaligned, byte, flush and non-access vectors (all stay IDLE)
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,2'b01,32'h100,32'h0,1'b1,32'hDEADBEEF,
                    1'b1,1'b0,1'b0,32'h100,32'h0,1'b0,1'b0,32'hDEADBEEF};
        vecs[1] = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h204,32'hA5A5A5A5,1'b1,32'h12345678,
                    1'b1,1'b1,1'b0,32'h204,32'hA5A5A5A5,1'b0,1'b0,32'h12345678};
        vecs[2] = '{1'b0,1'b0,1'b0,1'b0,2'b01,32'h102,32'h0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,32'h102,32'h0,1'b0,1'b1,32'h0};
        vecs[3] = '{1'b0,1'b1,1'b0,1'b1,2'b01,32'h204,32'h0,1'b0,32'h77777777,
                    1'b0,1'b0,1'b0,32'h204,32'h0,1'b0,1'b1,32'h0};
        vecs[4] = '{1'b0,1'b1,1'b0,1'b0,2'b01,32'h103,32'h0,1'b1,32'h000000AB,
                    1'b1,1'b0,1'b1,32'h103,32'h0,1'b0,1'b0,32'h000000AB};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b0,2'b01,32'h100,32'h0,1'b1,32'h1,
                    1'b0,1'b0,1'b0,32'h100,32'h0,1'b0,1'b0,32'h1};
        vecs[6] = '{1'b1,1'b0,1'b1,1'b0,2'b00,32'h102,32'hBEEF,1'b0,32'h0,
                    1'b0,1'b1,1'b0,32'h102,32'hBEEF,1'b0,1'b0,32'h0};
        vecs[7] = '{1'b0,1'b0,1'b0,1'b0,2'b10,32'h102,32'h0,1'b0,32'h0,
                    1'b0,1'b0,1'b0,32'h102,32'h0,1'b0,1'b0,32'h0};
        vecs[8] = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h101,32'h5A5A5A5A,1'b0,32'h0,
                    1'b0,1'b1,1'b0,32'h101,32'h5A5A5A5A,1'b0,1'b1,32'h0};
        vecs[9] = '{1'b0,1'b1,1'b1,1'b0,2'b00,32'h7,32'hCC,1'b1,32'h0,
                    1'b1,1'b1,1'b1,32'h7,32'hCC,1'b0,1'b0,32'h0};

        // reset: outputs forced low even with a valid access presented
        rst = 1'b1;
        drive(1'b0,1'b0,1'b0,1'b0,2'b01,32'h100,32'h0,32'h0,1'b1,32'h0);
        @(negedge clk);
        check("rst_req", 32'(mif.mem_req), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        next_cycle();
        drive(1'b0,1'b0,1'b0,1'b0,2'b01,32'h102,32'h0,32'h0,1'b0,32'h0);
        @(negedge clk);
        check("rst_mis", 32'(misalign_err), 32'h0);
        check("rst_buserr", 32'(bus_err), 32'h0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fl, vecs[i].by, vecs[i].wr, vecs[i].dw, vecs[i].wb,
                  vecs[i].addr, vecs[i].wlo, 32'hFFFF0000, vecs[i].rdy, vecs[i].rdata);
            @(negedge clk);
            check($sformatf("v%0d_req", i),   32'(mif.mem_req),  32'(vecs[i].e_req));
            check($sformatf("v%0d_we", i),    32'(mif.mem_we),   32'(vecs[i].e_we));
            check($sformatf("v%0d_byte", i),  32'(mif.mem_byte), 32'(vecs[i].e_byte));
            check($sformatf("v%0d_addr", i),  mif.mem_addr,      vecs[i].e_addr);
            check($sformatf("v%0d_wdata", i), mif.mem_wdata,     vecs[i].e_wdata);
            check($sformatf("v%0d_stall", i), 32'(stall),        32'(vecs[i].e_stall));
            check($sformatf("v%0d_mis", i),   32'(misalign_err), 32'(vecs[i].e_mis));
            check($sformatf("v%0d_buserr", i), 32'(bus_err),     32'h0);
            check($sformatf("v%0d_rdlo", i),  rd_lo,             vecs[i].e_rdlo);
            next_cycle();
        end

        // DW load, ready every cycle
        drive(1'b0,1'b0,1'b0,1'b1,2'b01,32'h208,32'h0,32'h0,1'b1,32'h11111111);
        @(negedge clk);
        check("dwl_b0_req", 32'(mif.mem_req), 32'h1);
        check("dwl_b0_addr", mif.mem_addr, 32'h208);
        check("dwl_b0_stall", 32'(stall), 32'h1);
        next_cycle();
        mif.mem_rdata = 32'h22222222;
        @(negedge clk);
        check("dwl_b1_req", 32'(mif.mem_req), 32'h1);
        check("dwl_b1_addr", mif.mem_addr, 32'h20C);
        check("dwl_b1_stall", 32'(stall), 32'h0);
        check("dwl_rdlo", rd_lo, 32'h11111111);
        check("dwl_rdhi", rd_hi, 32'h22222222);
        next_cycle();
        drive(1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,32'h0);
        @(negedge clk);
        check("dwl_after_req", 32'(mif.mem_req), 32'h0);
        next_cycle();

        // DW store, beat 0 ready delayed 3 cycles
        drive(1'b0,1'b0,1'b1,1'b1,2'b00,32'h10,32'hCAFE0000,32'hCAFE0001,1'b0,32'h0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mif.mem_ready = 1'b1;
            @(negedge clk);
            check($sformatf("dws_b0c%0d_addr", c), mif.mem_addr, 32'h10);
            check($sformatf("dws_b0c%0d_wdata", c), mif.mem_wdata, 32'hCAFE0000);
            check($sformatf("dws_b0c%0d_we", c), 32'(mif.mem_we), 32'h1);
            check($sformatf("dws_b0c%0d_stall", c), 32'(stall), 32'h1);
            next_cycle();
        end
        @(negedge clk);
        check("dws_b1_addr", mif.mem_addr, 32'h14);
        check("dws_b1_wdata", mif.mem_wdata, 32'hCAFE0001);
        check("dws_b1_we", 32'(mif.mem_we), 32'h1);
        check("dws_b1_stall", 32'(stall), 32'h0);
        next_cycle();

        // timeout with TIMEOUT=4: bus_err on the 5th waiting cycle
        drive(1'b0,1'b0,1'b0,1'b0,2'b01,32'h40,32'h0,32'h0,1'b0,32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("to_c%0d_req", c), 32'(mif.mem_req), 32'h1);
            check($sformatf("to_c%0d_stall", c), 32'(stall), 32'h1);
            check($sformatf("to_c%0d_buserr", c), 32'(bus_err), 32'h0);
            next_cycle();
        end
        @(negedge clk);
        check("to_c4_buserr", 32'(bus_err), 32'h1);
        check("to_c4_stall", 32'(stall), 32'h0);
        next_cycle();
        drive(1'b0,1'b0,1'b0,1'b0,2'b00,32'h40,32'h0,32'h0,1'b0,32'h0);
        @(negedge clk);
        check("to_after_req", 32'(mif.mem_req), 32'h0);
        check("to_after_buserr", 32'(bus_err), 32'h0);
        next_cycle();

        // flush at beat 0 completion abandons beat 1
        drive(1'b0,1'b0,1'b0,1'b1,2'b01,32'h300,32'h0,32'h0,1'b0,32'h0);
        @(negedge clk);
        check("fl_b0_stall", 32'(stall), 32'h1);
        next_cycle();
        ex_flush = 1'b1;
        mif.mem_ready = 1'b1;
        @(negedge clk);
        check("fl_done_req", 32'(mif.mem_req), 32'h1);
        check("fl_done_stall", 32'(stall), 32'h0);
        next_cycle();
        @(negedge clk);
        check("fl_after_req", 32'(mif.mem_req), 32'h0);
        next_cycle();

        // reset while in B1 clears lo_q and returns to IDLE
        drive(1'b0,1'b0,1'b0,1'b1,2'b01,32'h208,32'h0,32'h0,1'b1,32'h55AA55AA);
        @(negedge clk);
        check("rb1_b0_stall", 32'(stall), 32'h1);
        next_cycle();
        rst = 1'b1;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        check("rb1_rst_req", 32'(mif.mem_req), 32'h0);
        check("rb1_rst_stall", 32'(stall), 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(1'b1,1'b0,1'b0,1'b1,2'b01,32'h208,32'h0,32'h0,1'b1,32'h99999999);
        @(negedge clk);
        check("rb1_after_req", 32'(mif.mem_req), 32'h0);
        check("rb1_after_stall", 32'(stall), 32'h0);
        check("rb1_after_lo", rd_lo, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
